ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
- AHB-Lite slave with an SRAM-style memory and programmable wait states.
- Acts as the responder on the AHB side of axi2ahb_bridge: it consumes the bridge's haddr/htrans/hwrite/hsize/hburst/hwdata and returns hrdata/hready/hresp.
- Used as the memory model in bridge benches and as an on-chip scratch memory.
- Supports byte, halfword and word accesses; reports ERROR for illegal accesses with the two-cycle AHB error response.

Parameters:
- W_ADDR, 32, address width.
- W_DATA, 32, data width (fixed at 32; hsize above 3'b010 is illegal).
- MEM_DEPTH, 1024, number of 32-bit words.
- WAIT_CYCLES, 0, wait states inserted before each NONSEQ/SEQ data phase completes (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ahb_hsel  in  1  slave select.
- ahb_haddr  in  W_ADDR  address.
- ahb_htrans  in  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- ahb_hwrite  in  1  1=write.
- ahb_hsize  in  3  transfer size.
- ahb_hburst  in  3  burst type; informational only, because the address is taken per beat.
- ahb_hwdata  in  W_DATA  write data, valid in the data phase.
- ahb_hready_in  in  1  bus-level hready; qualifies address-phase sampling.
- ahb_hreadyout  out  1  slave ready.
- ahb_hresp  out  2  OKAY=00, ERROR=01; RETRY/SPLIT are never driven.
- ahb_hrdata  out  W_DATA  read data.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, hreadyout=1, hresp=00, hrdata=0, wait counter=0.
  - Memory contents are not reset.
- Address phase accepted when hsel & hready_in & htrans[1]. The slave registers haddr, hwrite, hsize and the byte-lane mask.
- Legality is checked at acceptance. The access is illegal if any of these holds:
  - hsize > 3'b010;
  - the address is misaligned to hsize (half: haddr[0]!=0; word: haddr[1:0]!=0);
  - haddr[W_ADDR-1:2] >= MEM_DEPTH.
- Lane mask:
  - byte: 1 << haddr[1:0];
  - half: 4'b0011 << haddr[1:0];
  - word: 4'b1111.
- State machine:
  - IDLE/DONE:
    - On a legal accept with WAIT_CYCLES=0, the next cycle is the data phase with hreadyout=1 and the state stays DONE.
    - On a legal accept with WAIT_CYCLES>0, go to WAIT and load counter=WAIT_CYCLES.
    - On an illegal accept, go to ERR1.
  - WAIT: hreadyout=0, hresp=00; counter decrements each cycle. At counter==1, the next cycle is the completing data phase (hreadyout=1).
  - ERR1: hreadyout=0, hresp=01, then go to ERR2.
  - ERR2: hreadyout=1, hresp=01. No memory access occurs.
  - A new address phase presented during the completing cycle (ERR2 or the final data phase) is accepted in the same cycle, giving back-to-back transfers.
- Write:
  - Memory is updated on the clock edge that completes the data phase (hreadyout=1), using the registered lane mask and the current hwdata.
  - Unselected lanes are unchanged.
- Read:
  - hrdata holds the full 32-bit word at the registered address and is valid in the completing cycle.
  - All lanes are driven; the master picks its lanes.
  - hrdata is 0 outside completing read cycles.
- Back-to-back write followed by a read of the same address: the read returns the newly written data. The write lands at the edge where the read's address phase is sampled, and the read uses the updated array.
- IDLE, BUSY, or hsel=0: no memory action, zero-wait OKAY (hreadyout=1, hresp=00). BUSY within a burst does not disturb the pending burst state.
- An address phase seen while hready_in=0 is ignored. The master must hold it.
- rst_n asserted mid-WAIT or mid-ERR: return to reset values immediately; the pending write is discarded.
- No combinational path from inputs to hreadyout/hresp. hrdata may be read combinationally from the registered address.

Decomposition:
- Package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HRESP_OKAY/ERROR;
  - HSIZE_BYTE/HALF/WORD;
  - the state encoding (IDLE, WAIT, DONE, ERR1, ERR2);
  - the lane_mask function.
- One sub-module: ahb_sram_mem, a byte-enabled single-port array with one write and one async read port.

Test Plan:
- Reset, WAIT_CYCLES=0: NONSEQ word write 0x10 <= 0xDEADBEEF, then read 0x10 -> hreadyout=1 each data phase, hrdata=0xDEADBEEF, hresp=00.
- Byte writes 0xAA@0x21, 0xBB@0x22 over an initial word 0x11223344@0x20 -> read 0x20 returns 0x11BBAA44. Halfword 0x5566@0x22 -> 0x5566AA44.
- WAIT_CYCLES=2: INCR4 write 0x40..0x4C with data 1..4 -> each beat shows exactly 2 cycles of hreadyout=0. An INCR4 read then returns 1,2,3,4.
- Illegal accesses -> ERR1 (hreadyout=0, hresp=01) then ERR2 (hreadyout=1, hresp=01), and memory is unchanged. Cases:
  - word write to 0x1002 (misaligned);
  - read of MEM_DEPTH*4 (out of range);
  - hsize=3'b011.
- Burst with BUSY inserted between beats 2 and 3 -> BUSY cycle is zero-wait OKAY and the remaining beats write correctly. IDLE with hsel=0 -> no write.
- rst_n pulled low during WAIT of a write to 0x80 (prior value 0x0) -> outputs reset asynchronously and a later read of 0x80 returns 0x0.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
`default_nettype none
//==============================================================================
// Module   : ahb_pkg
// Brief    : AHB-Lite encodings, slave state encoding and byte-lane helper
// Revision : 1.0
//==============================================================================
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    // Oversized hsize returns all lanes; such accesses are rejected before use.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        case (size)
            HSIZE_BYTE: lane_mask = 4'b0001 << addr_lo;
            HSIZE_HALF: lane_mask = 4'b0011 << addr_lo;
            default:    lane_mask = 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_slave_if.sv
`default_nettype none
//==============================================================================
// Module   : ahb_sram_slave_if
// Brief    : AHB-Lite bus bundle between a master and the SRAM slave
// Revision : 1.0
//==============================================================================
interface ahb_sram_slave_if #(
    parameter int W_ADDR = 32,
    parameter int W_DATA = 32
);
    logic              hsel;
    logic [W_ADDR-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [W_DATA-1:0] hwdata;
    logic              hready_in;
    logic              hreadyout;
    logic [1:0]        hresp;
    logic [W_DATA-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
        output hreadyout, hresp, hrdata
    );
endinterface
`default_nettype wire

// File: rtl/ahb_sram_slave_mem.sv
`default_nettype none
//==============================================================================
// Module   : ahb_sram_mem
// Brief    : Byte-enabled word array, one synchronous write and one async read
// Revision : 1.0
//==============================================================================
module ahb_sram_mem #(
    parameter int DEPTH = 1024,
    parameter int W_IDX = 10
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [W_IDX-1:0] addr_i,
    input  logic [3:0]       be_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);
    // One array per byte lane keeps each lane's writer independent.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] lane_q [DEPTH];

        always_ff @(posedge clk) begin
            if (we_i && be_i[b]) begin
                lane_q[addr_i] <= wdata_i[8*b +: 8];
            end
        end

        assign rdata_o[8*b +: 8] = lane_q[addr_i];
    end
endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
//==============================================================================
// Module   : ahb_sram_slave
// Brief    : AHB-Lite SRAM slave with programmable wait states and ERROR replies
// Revision : 1.0
//==============================================================================
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int W_ADDR      = 32,
    parameter int W_DATA      = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    ahb_sram_slave_if.slave ahb
);
    localparam int W_IDX = $clog2(MEM_DEPTH);

    state_t             state_q;
    logic               hreadyout_q;
    logic [1:0]         hresp_q;
    logic [3:0]         cnt_q;
    logic [W_IDX-1:0]   addr_q;
    logic               write_q;
    logic [3:0]         mask_q;

    logic               accept;
    logic               misaligned;
    logic               out_of_range;
    logic               illegal;
    logic               mem_we;
    logic [W_DATA-1:0]  mem_rdata;

    // Acceptance is also gated by our own ready so a stray hready_in can never
    // start a new transfer while one is still stalled here.
    always_comb begin
        accept       = ahb.hsel & ahb.hready_in & ahb.htrans[1] & hreadyout_q;
        misaligned   = ((ahb.hsize == HSIZE_HALF) && ahb.haddr[0]) ||
                       ((ahb.hsize == HSIZE_WORD) && (ahb.haddr[1:0] != 2'b00));
        out_of_range = {2'b00, ahb.haddr[W_ADDR-1:2]} >= W_ADDR'(MEM_DEPTH);
        illegal      = (ahb.hsize > HSIZE_WORD) | misaligned | out_of_range;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            mask_q      <= 4'b0000;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q     <= ST_DONE;
                        hreadyout_q <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_q     <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        addr_q  <= ahb.haddr[W_IDX+1:2];
                        write_q <= ahb.hwrite;
                        mask_q  <= lane_mask(ahb.hsize, ahb.haddr[1:0]);
                        if (illegal) begin
                            state_q     <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else if (WAIT_CYCLES == 0) begin
                            state_q     <= ST_DONE;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= HRESP_OKAY;
                        end else begin
                            state_q     <= ST_WAIT;
                            cnt_q       <= 4'(WAIT_CYCLES);
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_OKAY;
                        end
                    end else begin
                        state_q     <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // ST_DONE is always the completing data phase of a legal transfer.
    assign mem_we = (state_q == ST_DONE) && write_q;

    ahb_sram_mem #(
        .DEPTH (MEM_DEPTH),
        .W_IDX (W_IDX)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .addr_i  (addr_q),
        .be_i    (mask_q),
        .wdata_i (ahb.hwdata),
        .rdata_o (mem_rdata)
    );

    assign ahb.hreadyout = hreadyout_q;
    assign ahb.hresp     = hresp_q;
    assign ahb.hrdata    = ((state_q == ST_DONE) && !write_q) ? mem_rdata : '0;
endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
//==============================================================================
// Module   : tb_ahb_sram_slave
// Brief    : Bench for ahb_sram_slave, zero-wait and two-wait instances on one bus
// Revision : 1.0
//==============================================================================
module tb_ahb_sram_slave;
    import ahb_pkg::*;

    localparam int DEPTH = 1024;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        m_hsel = 1'b0;
    logic [31:0] m_haddr = '0;
    logic [1:0]  m_htrans = HTRANS_IDLE;
    logic        m_hwrite = 1'b0;
    logic [2:0]  m_hsize = HSIZE_WORD;
    logic [2:0]  m_hburst = 3'b000;
    logic [31:0] m_hwdata = '0;
    logic        bus_hready;
    logic [1:0]  bus_hresp;
    logic [31:0] bus_hrdata;

    int          n_total = 0;
    int          n_bad = 0;
    xfer_t       q[$];
    logic [31:0] res_rd [64];
    logic [7:0]  mdl [int];

    ahb_sram_slave_if if0 ();
    ahb_sram_slave_if if1 ();

    assign if0.hsel   = m_hsel & ~sel;
    assign if1.hsel   = m_hsel & sel;
    assign if0.haddr  = m_haddr;   assign if1.haddr  = m_haddr;
    assign if0.htrans = m_htrans;  assign if1.htrans = m_htrans;
    assign if0.hwrite = m_hwrite;  assign if1.hwrite = m_hwrite;
    assign if0.hsize  = m_hsize;   assign if1.hsize  = m_hsize;
    assign if0.hburst = m_hburst;  assign if1.hburst = m_hburst;
    assign if0.hwdata = m_hwdata;  assign if1.hwdata = m_hwdata;
    assign bus_hready = sel ? if1.hreadyout : if0.hreadyout;
    assign bus_hresp  = sel ? if1.hresp     : if0.hresp;
    assign bus_hrdata = sel ? if1.hrdata    : if0.hrdata;
    assign if0.hready_in = bus_hready;
    assign if1.hready_in = bus_hready;

    ahb_sram_slave #(.W_ADDR(32), .W_DATA(32), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .ahb(if0));
    ahb_sram_slave #(.W_ADDR(32), .W_DATA(32), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(2))
        u_dut1 (.clk(clk), .rst_n(rst_n), .ahb(if1));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, expv);
        end
    endtask

    function automatic int mkey(input int a);
        return (int'(sel) << 28) | a;
    endfunction

    function automatic int waitc();
        return sel ? 2 : 0;
    endfunction

    task automatic add(input logic [31:0] a, input logic [1:0] t, input logic w,
                       input logic [2:0] s, input logic [31:0] d);
        xfer_t x;
        x.addr = a; x.trans = t; x.wr = w; x.size = s; x.wdata = d;
        q.push_back(x);
    endtask

    task automatic drive_addr(input int i);
        m_hsel = 1'b1; m_haddr = q[i].addr; m_htrans = q[i].trans;
        m_hwrite = q[i].wr; m_hsize = q[i].size;
    endtask

    task automatic drive_idle();
        m_hsel = 1'b0; m_htrans = HTRANS_IDLE; m_hwrite = 1'b0;
    endtask

    // Byte-addressed memory model: a legal access touches 2**size bytes at addr.
    task automatic complete(input int idx, input int waits, input logic [1:0] wresp);
        xfer_t       x;
        logic [31:0] rd, expv;
        logic [1:0]  resp;
        bit          legal, known;
        int          nb, a;
        x = q[idx]; rd = bus_hrdata; resp = bus_hresp; res_rd[idx] = rd;
        if (!x.trans[1]) begin
            check_val("idle_waits", waits, 0);
            check_val("idle_resp", resp, HRESP_OKAY);
            check_val("idle_rdata", rd, 0);
            return;
        end
        nb = 1 << int'(x.size);
        legal = (x.size <= 3'd2) && ((x.addr % nb) == 0) && ((x.addr / 4) < DEPTH);
        check_val("waits", waits, legal ? waitc() : 1);
        if (waits > 0) check_val("wait_resp", wresp, legal ? HRESP_OKAY : HRESP_ERROR);
        check_val("resp", resp, legal ? HRESP_OKAY : HRESP_ERROR);
        if (!legal) return;
        if (x.wr) begin
            for (int i = 0; i < nb; i++) begin
                a = int'(x.addr) + i;
                mdl[mkey(a)] = x.wdata[8*(a%4) +: 8];
            end
            check_val("wr_rdata", rd, 0);
        end else begin
            known = 1'b1; expv = '0;
            for (int i = 0; i < 4; i++) begin
                a = int'(x.addr & ~32'd3) + i;
                if (mdl.exists(mkey(a))) expv[8*i +: 8] = mdl[mkey(a)];
                else known = 1'b0;
            end
            if (known) check_val("rd_data", rd, expv);
        end
    endtask

    // Pipelined master: the next address is shown while the previous beat is in its data phase.
    task automatic run();
        int cur, dph, nq, guard, waits;
        logic rdy;
        logic [1:0] wresp;
        nq = q.size(); dph = -1; cur = 0; guard = 0; waits = 0; wresp = HRESP_OKAY;
        @(posedge clk); #1;
        drive_addr(0);
        while (cur < nq || dph >= 0) begin
            @(negedge clk);
            rdy = bus_hready;
            if (dph >= 0) begin
                if (rdy) complete(dph, waits, wresp);
                else begin
                    if (waits == 0) wresp = bus_hresp;
                    waits++;
                end
            end
            @(posedge clk); #1;
            if (rdy) begin
                dph = (cur < nq) ? cur : -1;
                waits = 0; wresp = HRESP_OKAY;
                if (dph >= 0) m_hwdata = q[dph].wdata;
                if (cur < nq) cur++;
                if (cur < nq) drive_addr(cur);
                else drive_idle();
            end
            guard++;
            if (guard > 200) begin
                check_val("timeout", 1, 0);
                drive_idle();
                break;
            end
        end
        q.delete();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_rdy0", if0.hreadyout, 1);
        check_val("rst_resp0", if0.hresp, HRESP_OKAY);
        check_val("rst_rdata0", if0.hrdata, 0);
        check_val("rst_rdy1", if1.hreadyout, 1);

        // Zero-wait instance: write then back-to-back read of the same word
        sel = 1'b0;
        add(32'h10, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hDEADBEEF);
        add(32'h10, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        run();
        check_val("rd_10", res_rd[1], 32'hDEADBEEF);

        add(32'h20, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h11223344);
        add(32'h21, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'hAAAAAAAA);
        add(32'h22, HTRANS_NONSEQ, 1'b1, HSIZE_BYTE, 32'hBBBBBBBB);
        add(32'h20, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        add(32'h22, HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'h55660000);
        add(32'h20, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        run();
        check_val("byte_merge", res_rd[3], 32'h11BBAA44);
        check_val("half_merge", res_rd[5], 32'h5566AA44);

        // Illegal accesses on the zero-wait instance, then confirm nothing changed
        add(32'h1002, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hFFFFFFFF);
        add(DEPTH*4,  HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        add(32'h10,   HTRANS_NONSEQ, 1'b0, 3'b011,     32'h0);
        add(32'h22,   HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hFFFFFFFF);
        add(32'h21,   HTRANS_NONSEQ, 1'b1, HSIZE_HALF, 32'hFFFFFFFF);
        add(32'h20,   HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        run();
        check_val("err_keep", res_rd[5], 32'h5566AA44);

        // Burst with a BUSY slot between beats 2 and 3
        m_hburst = 3'b011;
        add(32'h60, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hA0);
        add(32'h64, HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'hA1);
        add(32'h68, HTRANS_BUSY,   1'b1, HSIZE_WORD, 32'hEE);
        add(32'h68, HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'hA2);
        add(32'h6C, HTRANS_SEQ,    1'b1, HSIZE_WORD, 32'hA3);
        run();
        m_hburst = 3'b000;

        // Address phase with hsel low must not write
        m_hsel = 1'b0; m_htrans = HTRANS_NONSEQ; m_hwrite = 1'b1;
        m_haddr = 32'h60; m_hsize = HSIZE_WORD; m_hwdata = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        #1 drive_idle();
        @(negedge clk);
        check_val("nosel_rdy", bus_hready, 1);
        check_val("nosel_resp", bus_hresp, HRESP_OKAY);
        for (int i = 0; i < 4; i++) add(32'h60 + 4*i, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        run();
        check_val("busy_b0", res_rd[0], 32'hA0);
        check_val("busy_b2", res_rd[2], 32'hA2);

        // Two-wait instance: INCR4 write and read back
        sel = 1'b1;
        m_hburst = 3'b011;
        for (int i = 0; i < 4; i++)
            add(32'h40 + 4*i, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, HSIZE_WORD, i + 1);
        run();
        for (int i = 0; i < 4; i++)
            add(32'h40 + 4*i, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, HSIZE_WORD, 32'h0);
        run();
        m_hburst = 3'b000;
        for (int i = 0; i < 4; i++) check_val("incr4_rd", res_rd[i], i + 1);
        add(32'h1002, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'hFFFFFFFF);
        add(DEPTH*4,  HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        add(32'h44,   HTRANS_NONSEQ, 1'b0, 3'b011,     32'h0);
        add(32'h44,   HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        run();

        // Randomized traffic on both instances over a pre-initialised window
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            for (int i = 0; i < 32; i++) add(32'h100 + 4*i, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, $urandom);
            run();
            for (int r = 0; r < 6; r++) begin
                int n;
                n = $urandom_range(1, 8);
                for (int i = 0; i < n; i++) begin
                    int k, sz;
                    logic [31:0] a;
                    k  = $urandom_range(0, 9);
                    sz = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
                    a  = (k == 0) ? 32'(DEPTH*4 + 4*$urandom_range(0, 15)) : 32'(32'h100 + $urandom_range(0, 127));
                    if (sz < 3 && $urandom_range(0, 3) != 0) a = a & ~32'((1 << sz) - 1);
                    add(a, (k == 9) ? HTRANS_BUSY : ((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ),
                        1'($urandom_range(0, 1)), 3'(sz), $urandom);
                end
                run();
            end
        end

        // Asynchronous reset during the wait states of a write
        sel = 1'b1;
        add(32'h80, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'h0);
        run();
        @(posedge clk); #1;
        m_hsel = 1'b1; m_haddr = 32'h80; m_htrans = HTRANS_NONSEQ;
        m_hwrite = 1'b1; m_hsize = HSIZE_WORD;
        @(posedge clk); #1;
        m_hwdata = 32'h12345678;
        drive_idle();
        @(negedge clk);
        check_val("mid_wait_rdy", bus_hready, 0);
        rst_n = 1'b0;
        #1;
        check_val("arst_rdy", bus_hready, 1);
        check_val("arst_resp", bus_hresp, HRESP_OKAY);
        check_val("arst_rdata", bus_hrdata, 0);
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        add(32'h80, HTRANS_NONSEQ, 1'b0, HSIZE_WORD, 32'h0);
        run();
        check_val("arst_discard", res_rd[0], 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
